sysid_check_master: RTL and testbench

- Avalon-MM read master that interrogates the system-ID slave at boot, or on request.
- Reads the ID word (offset 0) and the timestamp word (offset 1), then compares both against build-time expected values.
- Retries on mismatch up to a limit and reports a latched pass/fail verdict.
- Sits between the boot/reset controller and the sysid control_slave; its verdict gates CPU release.

---
 rtl/sysid_check_master.sv | 122 ++++++++++++
 tb/tb_sysid_check_master.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_master.sv
// Boot-time system-ID checker: an Avalon-MM read master that fetches the ID and timestamp words
// and latches a pass/fail verdict. Define SYSID_CHECK_TIMEOUT_EN to build the waitrequest stall timeout.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1581413829,
  parameter int          MAX_RETRIES        = 3,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout
);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_t;

  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRIES);

  state_t     state, state_nx;
  logic [3:0] retry_cnt;
  logic       accept, id_bad, ts_bad, retry, stall_limit;

  assign accept = avm_read & ~avm_waitrequest;
  assign id_bad = (id_value != EXPECTED_ID);
  assign ts_bad = (ts_value != EXPECTED_TIMESTAMP);
  assign retry  = (id_bad | ts_bad) && (retry_cnt < RETRY_LIM);

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam logic [15:0] STALL_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] stall_cnt;

  // Any non-stalled cycle (including the accept that ends a read) restarts the count.
  always_ff @(posedge clock) begin
    if (reset || !(avm_read && avm_waitrequest)) stall_cnt <= '0;
    else                                         stall_cnt <= stall_cnt + 16'd1;
  end

  assign stall_limit = avm_read & avm_waitrequest & (stall_cnt == STALL_LIM);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^(16'(TIMEOUT_CYCLES));
  assign stall_limit        = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RD_ID;
      RD_ID: begin
        avm_read = 1'b1;
        if (accept)           state_nx = RD_TS;
        else if (stall_limit) state_nx = DONE;
      end
      RD_TS: begin
        avm_read    = 1'b1;
        avm_address = 1'b1;
        if (accept)           state_nx = CHECK;
        else if (stall_limit) state_nx = DONE;
      end
      CHECK: state_nx = retry ? RD_ID : DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      retry_cnt   <= '0;
      pass        <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          pass        <= 1'b0;
          id_mismatch <= 1'b0;
          ts_mismatch <= 1'b0;
          timeout     <= 1'b0;
          retry_cnt   <= '0;
        end
        RD_ID: begin
          if (accept)           id_value <= avm_readdata;
          else if (stall_limit) timeout  <= 1'b1;
        end
        RD_TS: begin
          if (accept)           ts_value <= avm_readdata;
          else if (stall_limit) timeout  <= 1'b1;
        end
        CHECK: begin
          id_mismatch <= id_bad;
          ts_mismatch <= ts_bad;
          // The verdict is only written once no further retry will happen.
          if (retry) retry_cnt <= retry_cnt + 4'd1;
          else       pass      <= ~(id_bad | ts_bad);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: scripted/random sysid slave plus a per-pass cost model of the check.
module tb_sysid_check_master;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1581413829;
  localparam int          MAXR   = 3;
  localparam int          NREAD  = 2 * (MAXR + 1);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_value, ts_value;

  int errors = 0;
  int checks = 0;

  sysid_check_master #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .MAX_RETRIES(MAXR), .TIMEOUT_CYCLES(255)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(busy), .done(done), .pass(pass),
    .id_value(id_value), .ts_value(ts_value),
    .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Slave script: read n returns data_tab[n] after wait_tab[n] stall cycles.
  logic [31:0] data_tab [NREAD];
  int          wait_tab [NREAD];
  int          rd_idx, stall, proto_err;
  logic        slv_clr = 1'b1;

  always_comb begin
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'hDEADBEEF;
    if (avm_read && rd_idx < NREAD) begin
      avm_waitrequest = (stall < wait_tab[rd_idx]);
      if (!avm_waitrequest) avm_readdata = data_tab[rd_idx];
    end
  end

  always @(posedge clock) begin
    if (slv_clr) begin
      rd_idx <= 0; stall <= 0; proto_err <= 0;
    end else if (avm_read) begin
      if (rd_idx >= NREAD || avm_address !== rd_idx[0]) proto_err <= proto_err + 1;
      if (avm_waitrequest) stall <= stall + 1;
      else begin
        stall  <= 0;
        rd_idx <= rd_idx + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each pass costs two reads (1 cycle + stalls each) plus CHECK; done follows the last pass.
  function automatic void model(output int dcyc, output int npass,
                                output logic p, output logic idm, output logic tsm);
    dcyc = 1; npass = 0; idm = 1'b0; tsm = 1'b0;
    for (int k = 0; k <= MAXR; k++) begin
      dcyc += 3 + wait_tab[2*k] + wait_tab[2*k+1];
      idm   = (data_tab[2*k]   != EXP_ID);
      tsm   = (data_tab[2*k+1] != EXP_TS);
      npass = k + 1;
      if (!idm && !tsm) break;
    end
    p = !(idm || tsm);
  endfunction

  task automatic clean_tab();
    for (int k = 0; k <= MAXR; k++) begin
      data_tab[2*k] = EXP_ID; data_tab[2*k+1] = EXP_TS;
      wait_tab[2*k] = 0;      wait_tab[2*k+1] = 0;
    end
  endtask

  task automatic run(input string name, input int extra_start);
    int dcyc, np, cyc;
    logic p, im, tm;
    bit seen;
    model(dcyc, np, p, im, tm);
    @(posedge clock); #1; start = 1'b1; slv_clr = 1'b1;
    @(posedge clock); #1; start = 1'b0; slv_clr = 1'b0; cyc = 1;
    chk({name, "/busy_c1"}, busy, 1);
    chk({name, "/read_c1"}, {avm_read, avm_address}, 2'b10);
    seen = 0;
    while (cyc < 300) begin
      if (done) begin seen = 1; break; end
      @(posedge clock); #1; cyc++;
      start = (cyc == extra_start);
    end
    chk({name, "/done_seen"}, seen, 1);
    chk({name, "/done_cycle"}, cyc, dcyc);
    chk({name, "/pass"}, pass, p);
    chk({name, "/id_mm"}, id_mismatch, im);
    chk({name, "/ts_mm"}, ts_mismatch, tm);
    chk({name, "/id_value"}, id_value, data_tab[2*(np-1)]);
    chk({name, "/ts_value"}, ts_value, data_tab[2*np-1]);
    chk({name, "/timeout"}, timeout, 0);
    @(posedge clock); #1; start = 1'b0;
    chk({name, "/reads"}, rd_idx, 2*np);
    chk({name, "/proto"}, proto_err, 0);
    chk({name, "/idle_after"}, {busy, done}, 2'b00);
  endtask

  initial begin
    bit saw_done;
    clean_tab();
    repeat (3) @(posedge clock);
    #1;
    chk("reset/ctl", {busy, done, pass, avm_read, avm_address}, 5'b0);
    chk("reset/flags", {id_mismatch, ts_mismatch, timeout}, 3'b0);
    chk("reset/id_value", id_value, 0);
    chk("reset/ts_value", ts_value, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("idle/busy", busy, 0);

    clean_tab();
    run("match", -1);

    clean_tab();
    for (int k = 0; k <= MAXR; k++) data_tab[2*k] = 32'h1;
    run("id_bad_all", -1);

    clean_tab();
    data_tab[0] = 32'h1234;
    run("one_retry_busy_start", 2);

    clean_tab();
    wait_tab[0] = 5;
    run("stall_id_start_in_done", 9);

    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k <= MAXR; k++) begin
        data_tab[2*k]   = ($urandom_range(0, 1) != 0) ? EXP_ID : ($urandom() | 32'h1);
        data_tab[2*k+1] = ($urandom_range(0, 2) != 0) ? EXP_TS : (EXP_TS ^ ($urandom() | 32'h1));
        wait_tab[2*k]   = $urandom_range(0, 3);
        wait_tab[2*k+1] = $urandom_range(0, 3);
      end
      run($sformatf("rand%0d", it), int'($urandom_range(0, 15)));
    end

    // Reset landing in a stalled timestamp read.
    clean_tab();
    wait_tab[1] = 3;
    @(posedge clock); #1; start = 1'b1; slv_clr = 1'b1;
    @(posedge clock); #1; start = 1'b0; slv_clr = 1'b0;
    @(posedge clock); #1;
    chk("rst_mid/in_rd_ts", {avm_read, avm_address}, 2'b11);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid/read_drop", avm_read, 0);
    chk("rst_mid/busy", busy, 0);
    chk("rst_mid/done", done, 0);
    chk("rst_mid/id_value", id_value, 0);
    reset = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (done || busy) saw_done = 1;
    end
    chk("rst_mid/no_verdict", saw_done, 0);
    clean_tab();
    run("after_reset", -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
